// File: rtl/random_delay_pkg.sv
// random_delay_pkg: shared FSM state type and prescaler sizing helper for random_delay_timer.
package random_delay_pkg;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} delay_state_t;
  function automatic int presc_width(input int tick_div);
    return tick_div > 1 ? $clog2(tick_div) : 1;
  endfunction
endpackage

// File: rtl/random_delay_timer_tick_prescaler.sv
// tick_prescaler: divides clk into one-cycle ticks every TICK_DIV cycles while enabled.
module tick_prescaler
  import random_delay_pkg::*;
#(
  parameter int TICK_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);
  localparam int PW = presc_width(TICK_DIV);
  logic [PW-1:0] cnt;
  assign tick = cnt == PW'(TICK_DIV - 1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/random_delay_timer.sv
// random_delay_timer: loads an LFSR word as a tick count, counts it down, then pulses time_out.
// Optional minimum-delay clamp enabled by defining RANDOM_DELAY_MIN_CLAMP_EN.
module random_delay_timer
  import random_delay_pkg::*;
#(
  parameter int WIDTH     = 7,
  parameter int TICK_DIV  = 1000,
  parameter int MIN_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger,
  input  logic             abort,
  input  logic [WIDTH-1:0] random_in,
  output logic             lfsr_en,
  output logic             busy,
  output logic [WIDTH-1:0] count,
  output logic             time_out
);
`ifdef RANDOM_DELAY_MIN_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif
  delay_state_t state, state_n;
  logic [WIDTH-1:0] count_n, load, min_w;
  logic tick, accept;
  assign min_w    = WIDTH'(MIN_DELAY);
  assign load     = CLAMP_EN && random_in < min_w ? min_w : random_in;
  assign accept   = state == IDLE && trigger && !abort;
  assign busy     = state != IDLE;
  assign time_out = state == DONE;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept || abort),
    .en   (state == COUNT),
    .tick (tick)
  );
  // abort outranks both a new load and a pending tick
  always_comb begin
    state_n = state;
    count_n = count;
    if (abort) begin
      state_n = IDLE;
      count_n = '0;
    end else if (accept) begin
      state_n = load != '0 ? COUNT : DONE;
      count_n = load;
    end else if (state == COUNT && tick) begin
      state_n = count == WIDTH'(1) ? DONE : COUNT;
      count_n = count - 1'b1;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count   <= '0;
      lfsr_en <= 1'b0;
    end else begin
      count   <= count_n;
      lfsr_en <= accept;
    end
endmodule

// File: tb/tb_random_delay_timer.sv
// tb_random_delay_timer: directed and random stimulus checked against an elapsed-time reference model.
module tb_random_delay_timer;
  localparam int W  = 7;
  localparam int TD = 4;
  localparam int MD = 2;
  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, abort = 1'b0;
  logic [W-1:0] random_in = '0;
  logic lfsr_en, busy, time_out;
  logic [W-1:0] count;
  int checks = 0, errors = 0;
  int cyc = 0, m_t0 = 0, m_n = 0;
  bit m_active = 1'b0, m_lfsr = 1'b0;

  random_delay_timer #(.WIDTH(W), .TICK_DIV(TD), .MIN_DELAY(MD)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .abort(abort), .random_in(random_in),
    .lfsr_en(lfsr_en), .busy(busy), .count(count), .time_out(time_out)
  );

  always #5 clk = ~clk;

  function automatic int eff(input int r);
`ifdef RANDOM_DELAY_MIN_CLAMP_EN
    return r < MD ? MD : r;
`else
    return r;
`endif
  endfunction

  // model: a delay of n ticks is busy for elapsed cycles 0..n*TD, expiring at n*TD
  function automatic bit m_busy();
    return m_active && (cyc - m_t0) <= m_n * TD;
  endfunction

  always @(posedge clk or posedge rst)
    if (rst) begin
      m_active <= 1'b0;
      m_lfsr   <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      if (abort) begin
        m_active <= 1'b0;
        m_lfsr   <= 1'b0;
      end else if (!m_busy() && trigger) begin
        m_active <= 1'b1;
        m_t0     <= cyc + 1;
        m_n      <= eff(int'(random_in));
        m_lfsr   <= 1'b1;
      end else begin
        m_lfsr <= 1'b0;
      end
    end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_all();
    int e;
    bit b;
    e = cyc - m_t0;
    b = m_busy();
    check("busy", int'(busy), int'(b));
    check("count", int'(count), b ? m_n - e / TD : 0);
    check("time_out", int'(time_out), int'(b && e == m_n * TD));
    check("lfsr_en", int'(lfsr_en), int'(m_lfsr));
  endtask

  task automatic step(input logic t, input logic a, input int r);
    @(negedge clk);
    check_all();
    trigger   = t;
    abort     = a;
    random_in = W'(r);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);
    check("reset_time_out", int'(time_out), 0);
    check("reset_lfsr_en", int'(lfsr_en), 0);
    rst = 1'b0;
    idle(2);
    step(1'b1, 1'b0, 5); idle(25);
    step(1'b1, 1'b0, 5); idle(9); step(1'b0, 1'b1, 0); idle(40);
    step(1'b1, 1'b0, 5); idle(13); step(1'b1, 1'b0, 9); idle(10);
    step(1'b1, 1'b0, 1); idle(10);
    step(1'b1, 1'b0, 0); idle(4);
    step(1'b1, 1'b0, 5); idle(6);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_count", int'(count), 0);
    check("rst_time_out", int'(time_out), 0);
    check("rst_lfsr_en", int'(lfsr_en), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(30);
    step(1'b1, 1'b1, 5); idle(6);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0, $urandom_range(0, 9));
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
